// File: rtl/cpu_pkg.sv
// Shared constants and types for the fetch/feed stage and its neighbours.
package cpu_pkg;

    localparam int WORD_W     = 16;
    localparam int K_FLAG_BIT = 15;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t RESET_VECTOR = 16'hFFFC;

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_BUSY = 1'b1
    } fetch_state_e;

    // An instruction word with the K flag set is followed by its constant.
    function automatic logic has_k(input word_t ir);
        return ir[K_FLAG_BIT];
    endfunction

endpackage

// File: rtl/fetch_feed_if.sv
// Program-memory fetch bus and decode handshake bundles.
interface fetch_mem_if;
    import cpu_pkg::*;

    logic  mem_req;
    word_t mem_addr;
    logic  mem_ack;
    word_t mem_data;

    // master issues requests, slave is the program memory
    modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);
endinterface

interface fetch_dec_if;
    import cpu_pkg::*;

    logic  dec_valid;
    logic  dec_ready;
    word_t dec_ir;
    word_t dec_k;
    word_t dec_pc;

    // master is the feed stage, slave is the decoder
    modport master (output dec_valid, output dec_ir, output dec_k, output dec_pc, input dec_ready);
    modport slave  (input dec_valid, input dec_ir, input dec_k, input dec_pc, output dec_ready);
endinterface

// File: rtl/fetch_queue.sv
// Small word FIFO with single push, one- or two-word pop and flush.
// The two head words are visible combinationally so an IR+K pair can issue at once.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     a_rst,
    input  logic                     push,
    input  word_t                    push_data,
    input  logic                     pop1,
    input  logic                     pop2,
    input  logic                     flush,
    output word_t                    head0,
    output word_t                    head1,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [PW:0]   pop_n;
    logic [PW-1:0] rd_ptr_p1;
    word_t         slot_q [DEPTH];
    word_t         slot_d [DEPTH];

    // Pointer and occupancy update; flush overrides everything.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        pop_n    = '0;
        if (pop2) begin
            pop_n = (PW+1)'(2);
        end else if (pop1) begin
            pop_n = (PW+1)'(1);
        end
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            rd_ptr_d = rd_ptr_q + pop_n[PW-1:0];
            if (pop2 && PW == 1) begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + {{PW{1'b0}}, push} - pop_n;
        end
    end

    // Storage write: the pushed word lands at the write pointer.
    always_comb begin
        slot_d = slot_q;
        if (push && !flush) begin
            slot_d[wr_ptr_q] = push_data;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // One register per queue slot.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        always_ff @(posedge clk or negedge a_rst) begin
            if (!a_rst) begin
                slot_q[gi] <= '0;
            end else begin
                slot_q[gi] <= slot_d[gi];
            end
        end
    end

    assign rd_ptr_p1 = rd_ptr_q + PW'(1);
    assign head0     = slot_q[rd_ptr_q];
    assign head1     = slot_q[rd_ptr_p1];
    assign count     = count_q;

endmodule

// File: rtl/fetch_feed.sv
// Instruction fetch and feed stage: prefetches program words into a queue,
// assembles IR(+K) pairs for decode and splices in injected instructions.
module fetch_feed
    import cpu_pkg::*;
#(
    parameter int    DEPTH    = 4,
    parameter word_t RESET_PC = RESET_VECTOR
) (
    input  logic        clk,
    input  logic        a_rst,
    fetch_mem_if.master mem,
    fetch_dec_if.master dec,
    input  logic        redirect,
    input  word_t       redirect_pc,
    input  logic        hold_fetch,
    input  logic        hold_decode,
    input  logic        replace_ir,
    input  logic        replace_k,
    input  word_t       int_ir,
    input  word_t       int_k,
    output logic        feed_ack,
    output logic [7:0]  ir_low
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        mem_addr_q, mem_addr_d;
    logic         drop_q, drop_d;
    word_t        head_pc_q, head_pc_d;
    word_t        last_pc_q, last_pc_d;
    logic         feed_ack_q, feed_ack_d;

    logic         q_push;
    logic         q_pop1;
    logic         q_pop2;
    word_t        q_head0;
    word_t        q_head1;
    logic [CW-1:0] q_count;

    logic         q_complete;
    logic         dec_valid_c;
    logic         xfer;
    word_t        dec_ir_c;
    word_t        dec_k_c;
    word_t        dec_pc_c;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .a_rst     (a_rst),
        .push      (q_push),
        .push_data (mem.mem_data),
        .pop1      (q_pop1),
        .pop2      (q_pop2),
        .flush     (redirect),
        .head0     (q_head0),
        .head1     (q_head1),
        .count     (q_count)
    );

    // Fetch FSM: one outstanding request, started only when a slot is free.
    // A redirect while a request is in flight marks its reply for discard.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_addr_d = mem_addr_q;
        drop_d     = drop_q;
        q_push     = 1'b0;
        unique case (state_q)
            FETCH_IDLE: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end else if (!hold_fetch && (q_count < CW'(DEPTH))) begin
                    state_d    = FETCH_BUSY;
                    mem_addr_d = pc_q;
                end
            end
            FETCH_BUSY: begin
                if (mem.mem_ack) begin
                    state_d = FETCH_IDLE;
                    drop_d  = 1'b0;
                    if (redirect) begin
                        pc_d = redirect_pc;
                    end else if (!drop_q) begin
                        q_push = 1'b1;
                        pc_d   = pc_q + 16'd1;
                    end
                end else if (redirect) begin
                    pc_d   = redirect_pc;
                    drop_d = 1'b1;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    // Issue path: injection beats queued words; a K-flagged IR needs its K queued too.
    always_comb begin
        q_complete  = (q_count != '0) && (!has_k(q_head0) || (q_count >= CW'(2)));
        dec_valid_c = !hold_decode && (replace_ir || q_complete);
        xfer        = dec_valid_c && dec.dec_ready;
        dec_ir_c    = '0;
        dec_k_c     = '0;
        dec_pc_c    = last_pc_q;
        q_pop1      = 1'b0;
        q_pop2      = 1'b0;
        if (dec_valid_c) begin
            if (replace_ir) begin
                dec_ir_c = int_ir;
                dec_k_c  = replace_k ? int_k : '0;
            end else begin
                dec_ir_c = q_head0;
                dec_k_c  = has_k(q_head0) ? q_head1 : '0;
                dec_pc_c = head_pc_q;
                q_pop1   = xfer && !has_k(q_head0);
                q_pop2   = xfer && has_k(q_head0);
            end
        end
        feed_ack_d = xfer && replace_ir;
        last_pc_d  = (xfer && !replace_ir) ? head_pc_q : last_pc_q;
        head_pc_d  = head_pc_q;
        if (redirect) begin
            head_pc_d = redirect_pc;
        end else if (q_pop2) begin
            head_pc_d = head_pc_q + 16'd2;
        end else if (q_pop1) begin
            head_pc_d = head_pc_q + 16'd1;
        end
    end

    // State registers; reset abandons any request in flight.
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state_q    <= FETCH_IDLE;
            pc_q       <= RESET_PC;
            mem_addr_q <= RESET_PC;
            drop_q     <= 1'b0;
            head_pc_q  <= RESET_PC;
            last_pc_q  <= '0;
            feed_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_addr_q <= mem_addr_d;
            drop_q     <= drop_d;
            head_pc_q  <= head_pc_d;
            last_pc_q  <= last_pc_d;
            feed_ack_q <= feed_ack_d;
        end
    end

    assign mem.mem_req   = (state_q == FETCH_BUSY);
    assign mem.mem_addr  = mem_addr_q;
    assign dec.dec_valid = dec_valid_c;
    assign dec.dec_ir    = dec_ir_c;
    assign dec.dec_k     = dec_k_c;
    assign dec.dec_pc    = dec_pc_c;
    assign ir_low        = dec_ir_c[7:0];
    assign feed_ack      = feed_ack_q;

endmodule
